// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared types and constants for the radix-2 restoring divider
package div_unit_pkg;

  localparam int DIV_W        = 32;
  localparam int DIV_RESULT_W = 64;
  localparam int STALL_W      = 6;
  localparam int STALL_EX_BIT = 3;
  localparam int CNT_W        = 6;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  // Two's-complement magnitude when neg is set, raw value otherwise.
  function automatic logic [DIV_W-1:0] abs_val(input logic [DIV_W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring division iteration
module div_step
  import div_unit_pkg::*;
(
  input  logic [DIV_W-1:0] rem_in,
  input  logic             dividend_msb,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] rem_out,
  output logic             quot_bit
);

  logic [DIV_W:0] shifted;
  logic [DIV_W:0] trial;

  // Trial subtract; a clear bit 32 means the shifted remainder covered the divisor.
  always_comb begin
    shifted  = {rem_in, dividend_msb};
    trial    = shifted - {1'b0, divisor};
    quot_bit = ~trial[DIV_W];
    rem_out  = quot_bit ? trial[DIV_W-1:0] : shifted[DIV_W-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle 32-bit signed/unsigned divider with EX stall request
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall,
  input  logic                    cancel,
  input  logic                    start,
  input  logic                    signed_div,
  input  logic [DIV_W-1:0]        opdata1,
  input  logic [DIV_W-1:0]        opdata2,
  output logic [DIV_RESULT_W-1:0] result,
  output logic                    ready,
  output logic                    stallreq_for_ex
);

  div_state_e              state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [DIV_W-1:0]        rem_q, rem_d;
  logic [DIV_W-1:0]        dividend_q, dividend_d;
  logic [DIV_W-1:0]        divisor_q, divisor_d;
  logic [DIV_W-1:0]        quot_q, quot_d;
  logic                    q_neg_q, q_neg_d;
  logic                    r_neg_q, r_neg_d;
  logic [DIV_RESULT_W-1:0] result_q, result_d;

  logic [DIV_W-1:0]        step_rem;
  logic                    step_qbit;
  logic [DIV_W-1:0]        quot_next;
  logic                    unused_stall_bits;

  // Only the EX hold bit of the stall bus matters to this unit.
  assign unused_stall_bits = ^{stall[STALL_W-1:STALL_EX_BIT+1], stall[STALL_EX_BIT-1:0]};

  div_step u_step (
    .rem_in       (rem_q),
    .dividend_msb (dividend_q[DIV_W-1]),
    .divisor      (divisor_q),
    .rem_out      (step_rem),
    .quot_bit     (step_qbit)
  );

  assign quot_next       = {quot_q[DIV_W-2:0], step_qbit};
  assign ready           = (state_q == DIV_END);
  assign result          = result_q;
  assign stallreq_for_ex = start & ~ready & ~rst & ~cancel;

  // Next-state and datapath update; cancel overrides every normal transition.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rem_d      = rem_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    result_d   = result_q;
    case (state_q)
      DIV_FREE: begin
        if (start) begin
          if (opdata2 == '0) begin
            state_d = DIV_BY_ZERO;
          end else begin
            state_d    = DIV_ON;
            dividend_d = abs_val(opdata1, signed_div & opdata1[DIV_W-1]);
            divisor_d  = abs_val(opdata2, signed_div & opdata2[DIV_W-1]);
            q_neg_d    = signed_div & (opdata1[DIV_W-1] ^ opdata2[DIV_W-1]);
            r_neg_d    = signed_div & opdata1[DIV_W-1];
            rem_d      = '0;
            quot_d     = '0;
            count_d    = '0;
          end
        end
      end
      DIV_BY_ZERO: begin
        state_d  = DIV_END;
        result_d = '0;
      end
      DIV_ON: begin
        rem_d      = step_rem;
        quot_d     = quot_next;
        dividend_d = {dividend_q[DIV_W-2:0], 1'b0};
        count_d    = count_q + 1'b1;
        if (count_q == CNT_W'(DIV_CYCLES - 1)) begin
          state_d  = DIV_END;
          result_d = {abs_val(step_rem, r_neg_q), abs_val(quot_next, q_neg_q)};
        end
      end
      DIV_END: begin
        if (!stall[STALL_EX_BIT]) begin
          state_d = DIV_FREE;
        end
      end
      default: state_d = DIV_FREE;
    endcase
    if (cancel) begin
      state_d  = DIV_FREE;
      count_d  = '0;
      result_d = '0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DIV_FREE;
      count_q    <= '0;
      rem_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      result_q   <= result_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        cancel;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        ready;
  logic        stallreq_for_ex;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  logic ready_prev = 1'b0;
  int   t0;

  div_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .cancel          (cancel),
    .start           (start),
    .signed_div      (signed_div),
    .opdata1         (opdata1),
    .opdata2         (opdata2),
    .result          (result),
    .ready           (ready),
    .stallreq_for_ex (stallreq_for_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every new ready pulse pops one expectation.
  always @(negedge clk) begin
    if (!rst && ready === 1'b1 && ready_prev !== 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected ready", 1'b0, result, 64'h0);
      end else begin
        mon_e = sb_q.pop_front();
        check("result", result === mon_e.res, result, mon_e.res);
        check("ready cycle", cyc == mon_e.cyc, 64'(cyc), 64'(mon_e.cyc));
      end
    end
    ready_prev <= ready;
  end

  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input int lat, output int ts);
    @(negedge clk);
    signed_div = sgn;
    opdata1    = a;
    opdata2    = b;
    start      = 1'b1;
    ts         = cyc;
    sb_q.push_back('{exp, ts + lat});
  endtask

  task automatic wait_done(input int ts, input int lat, input int hold,
                           input logic [63:0] exp, input string name);
    bit ok  = 1'b1;
    bit got = 1'b0;
    bit hok = 1'b1;
    for (int i = 0; i < lat + 8 && !got; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (ready === 1'b1) got = 1'b1;
      else if (stallreq_for_ex !== 1'b1) ok = 1'b0;
    end
    check({name, " stall window"}, ok && got, 64'(cyc - ts), 64'(lat));
    check({name, " stall low at ready"}, stallreq_for_ex === 1'b0, 64'(stallreq_for_ex), 64'h0);
    start = 1'b0;
    if (hold > 0) begin
      stall = 6'b001000;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        #1;
        if (ready !== 1'b1 || result !== exp) hok = 1'b0;
      end
      check({name, " held in done"}, hok, result, exp);
      stall = 6'b000000;
    end
  endtask

  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat, input int hold, input string name);
    int ts;
    issue(sgn, a, b, exp, lat, ts);
    wait_done(ts, lat, hold, exp, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    stall      = 6'b0;
    cancel     = 1'b0;
    start      = 1'b1;
    signed_div = 1'b0;
    opdata1    = 32'd0;
    opdata2    = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    check("reset result", result === 64'h0, result, 64'h0);
    check("reset ready", ready === 1'b0, 64'(ready), 64'h0);
    check("reset stallreq", stallreq_for_ex === 1'b0, 64'(stallreq_for_ex), 64'h0);
    start = 1'b0;
    rst   = 1'b0;

    run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0, "divu 100/7");
    run_div(1'b1, 32'hFFFFFFF8, 32'd3, {32'hFFFFFFFE, 32'hFFFFFFFE}, 33, 0, "div -8/3");
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 33, 0, "div 7/-2");
    run_div(1'b0, 32'd12345, 32'd0, 64'h0, 2, 0, "div by zero");
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33, 0, "div min/-1");
    run_div(1'b0, 32'hFFFFFFFF, 32'h10, {32'hF, 32'h0FFFFFFF}, 33, 0, "divu ffffffff/16");

    // Cancel at T+10 then a fresh division accepted at T+11.
    @(negedge clk);
    signed_div = 1'b0;
    opdata1    = 32'd200;
    opdata2    = 32'd3;
    start      = 1'b1;
    t0         = cyc;
    repeat (10) @(negedge clk);
    cancel = 1'b1;
    #1;
    check("cancel stallreq drop", stallreq_for_ex === 1'b0, 64'(stallreq_for_ex), 64'h0);
    @(negedge clk);
    cancel  = 1'b0;
    opdata1 = 32'd1000;
    opdata2 = 32'd10;
    #1;
    check("cancel clears result", result === 64'h0 && ready === 1'b0, result, 64'h0);
    sb_q.push_back('{{32'd0, 32'd100}, t0 + 44});
    wait_done(t0 + 11, 33, 0, {32'd0, 32'd100}, "after cancel");

    // Reset at T+20 aborts the division and clears outputs.
    run_div(1'b0, 32'd9, 32'd4, {32'd1, 32'd2}, 33, 0, "divu 9/4");
    @(negedge clk);
    signed_div = 1'b1;
    opdata1    = 32'd50;
    opdata2    = 32'd5;
    start      = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst stallreq drop", stallreq_for_ex === 1'b0, 64'(stallreq_for_ex), 64'h0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    #1;
    check("rst clears outputs", result === 64'h0 && ready === 1'b0 && stallreq_for_ex === 1'b0,
          result, 64'h0);

    // Stall holds DONE three cycles, then a back-to-back division.
    run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 3, "hold 100/7");
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, 33, 0, "b2b ffffffff/1");

    repeat (3) @(negedge clk);
    check("scoreboard drained", sb_q.size() == 0, 64'(sb_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
